// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, widths and decoder-side opcode constants
// for the fetch sequencer (fetch_unit / next_pc_calc).
package fetch_pkg;

    // Default instruction word-address width (matches instruction_memory).
    localparam int ADDR_W_DEFAULT = 8;

    // Widths of the redirect fields coming from the decode stage.
    localparam int JT_W = 26;
    localparam int BO_W = 16;

    // Sequencer states; encoding is fixed so external checkers can decode it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // Opcodes the decoder uses to raise jump / branch_taken.
    localparam logic [5:0] OP_JUMP = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b001100;

endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational target generation for the fetch sequencer.
// Produces the sequential, jump and PC-relative branch targets, each truncated
// to ADDR_W bits, plus flags telling whether the untruncated value would have
// left the 0..2^ADDR_W-1 address range.
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic [ADDR_W-1:0] pc_next_i,
    input  logic [ADDR_W-1:0] fetch_pc_i,
    input  logic [JT_W-1:0]   jump_target_i,
    input  logic [BO_W-1:0]   branch_offset_i,
    output logic [ADDR_W-1:0] seq_pc_o,
    output logic [ADDR_W-1:0] jump_pc_o,
    output logic [ADDR_W-1:0] branch_pc_o,
    output logic              seq_ovf_o,
    output logic              jump_oor_o,
    output logic              branch_oor_o
);

    // Wide enough that fetch_pc + 1 + sext(offset) never overflows, so any
    // set bit above ADDR_W-1 (including the sign) means out of range.
    localparam int SW = ADDR_W + BO_W + 2;

    logic [SW-1:0] branch_sum;

    // Target arithmetic and range flags.
    always_comb begin
        branch_sum   = {{(SW-ADDR_W){1'b0}}, fetch_pc_i}
                     + SW'(1)
                     + {{(SW-BO_W){branch_offset_i[BO_W-1]}}, branch_offset_i};
        seq_pc_o     = pc_next_i + ADDR_W'(1);
        seq_ovf_o    = &pc_next_i;
        jump_pc_o    = jump_target_i[ADDR_W-1:0];
        jump_oor_o   = |jump_target_i[JT_W-1:ADDR_W];
        branch_pc_o  = branch_sum[ADDR_W-1:0];
        branch_oor_o = |branch_sum[SW-1:ADDR_W];
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and fetch sequencer feeding a 1-cycle-latency
// synchronous instruction ROM. Tracks the PC of the word on instruction_out,
// qualifies it with instr_valid, squashes the wrong-path word after a redirect
// and obeys start/stall/halt from the downstream decode stage.
// Optional feature: define PC_BOUNDS_CHECK_EN to trap address-range violations
// into the FAULT state; without it addresses wrap silently and fault is 0.
// Handshake: no valid/ready pair; instr_valid qualifies the ROM output in the
// cycle it is high, and stall holds that word for as long as it is asserted.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic              halt,
    input  logic              jump,
    input  logic [JT_W-1:0]   jump_target,
    input  logic              branch_taken,
    input  logic [BO_W-1:0]   branch_offset,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              instr_valid,
    output logic              running,
    output logic              halted,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

`ifdef PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_next_q;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic              instr_valid_q;

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] branch_pc;
    logic              seq_ovf;
    logic              jump_oor;
    logic              branch_oor;
    logic              hold_sel;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .pc_next_i       (pc_next_q),
        .fetch_pc_i      (fetch_pc_q),
        .jump_target_i   (jump_target),
        .branch_offset_i (branch_offset),
        .seq_pc_o        (seq_pc),
        .jump_pc_o       (jump_pc),
        .branch_pc_o     (branch_pc),
        .seq_ovf_o       (seq_ovf),
        .jump_oor_o      (jump_oor),
        .branch_oor_o    (branch_oor)
    );

    // Re-present the displayed PC while stalled so the ROM re-latches the same word.
    always_comb begin
        hold_sel     = (state_q == RUN) && stall && !jump && !branch_taken;
        read_address = hold_sel ? fetch_pc_q : pc_next_q;
    end

    // Sequencer FSM and PC registers; priority halt > jump > branch > stall > sequential.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_next_q     <= RESET_ADDR;
            fetch_pc_q    <= RESET_ADDR;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q       <= HALT;
                        instr_valid_q <= 1'b0;
                    end else if (jump) begin
                        instr_valid_q <= 1'b0;
                        if (BOUNDS_EN && jump_oor) begin
                            state_q <= FAULT;
                        end else begin
                            pc_next_q  <= jump_pc;
                            fetch_pc_q <= read_address;
                        end
                    end else if (branch_taken) begin
                        instr_valid_q <= 1'b0;
                        if (BOUNDS_EN && branch_oor) begin
                            state_q <= FAULT;
                        end else begin
                            pc_next_q  <= branch_pc;
                            fetch_pc_q <= read_address;
                        end
                    end else if (stall) begin
                        // Hold everything; the ROM re-reads fetch_pc.
                    end else if (BOUNDS_EN && seq_ovf) begin
                        state_q       <= FAULT;
                        instr_valid_q <= 1'b0;
                    end else begin
                        fetch_pc_q    <= pc_next_q;
                        pc_next_q     <= seq_pc;
                        instr_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // HALT and FAULT are absorbing until reset.
                end
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        fetch_pc    = fetch_pc_q;
        instr_valid = instr_valid_q;
        running     = (state_q == RUN);
        halted      = (state_q == HALT) || (state_q == FAULT);
`ifdef PC_BOUNDS_CHECK_EN
        fault       = (state_q == FAULT);
`else
        fault       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a
// behavioural model (integer PCs, mode number) plus a bench-side ROM that
// confirms the latched word always belongs to fetch_pc when instr_valid is set.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int AW  = 8;
  localparam int RPC = 0;
  localparam int N   = 1 << AW;
`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset, start, stall, halt, jump, branch_taken;
  logic [25:0]   jump_target;
  logic [15:0]   branch_offset;
  logic [AW-1:0] read_address, fetch_pc;
  logic          instr_valid, running, halted, fault;
  logic [31:0]   rom_q;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle 1=run 2=halt 3=fault
  int m_mode, m_next, m_disp;
  bit m_valid;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .read_address  (read_address),
    .fetch_pc      (fetch_pc),
    .instr_valid   (instr_valid),
    .running       (running),
    .halted        (halted),
    .fault         (fault)
  );

  function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Bench ROM with 1-cycle read latency.
  always @(posedge clk) rom_q <= rom_word(read_address);

  // ---------------- model ----------------
  function automatic int m_raddr();
    if (m_mode == 1 && stall && !jump && !branch_taken) return m_disp;
    return m_next;
  endfunction

  function automatic logic [2*AW+3:0] exp_vec();
    return {AW'(m_raddr()), AW'(m_disp), m_valid, (m_mode == 1), (m_mode >= 2),
            (BOUNDS && (m_mode == 3))};
  endfunction

  function automatic logic [2*AW+3:0] obs_vec();
    return {read_address, fetch_pc, instr_valid, running, halted, fault};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_next = RPC; m_disp = RPC; m_valid = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int sum;
    int ra;
    ra = m_raddr();
    if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt) begin
        m_mode = 2; m_valid = 0;
      end else if (jump) begin
        m_valid = 0;
        if (BOUNDS && int'(jump_target) >= N) m_mode = 3;
        else begin m_disp = ra; m_next = int'(jump_target) % N; end
      end else if (branch_taken) begin
        m_valid = 0;
        sum = m_disp + 1 + int'($signed(branch_offset));
        if (BOUNDS && (sum < 0 || sum >= N)) m_mode = 3;
        else begin m_disp = ra; m_next = ((sum % N) + N) % N; end
      end else if (stall) begin
        // nothing moves
      end else if (BOUNDS && m_next == N - 1) begin
        m_mode = 3; m_valid = 0;
      end else begin
        m_disp = m_next; m_next = (m_next + 1) % N; m_valid = 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    start = 0; stall = 0; halt = 0; jump = 0; branch_taken = 0;
    jump_target = '0; branch_offset = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic start_run();
    start = 1;
    tick();
    start = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs_vec() !== {AW'(RPC), AW'(RPC), 4'b0000}) begin
      errors++;
      $display("FAIL reset_values: dut=%h expected=%h", obs_vec(), {AW'(RPC), AW'(RPC), 4'b0000});
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_hold[%0d]: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sequential();
    logic [AW-1:0] ra_seen[4];
    do_reset();
    start_run();
    checks++;
    if (instr_valid !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL start_edge: valid=%b running=%b expected valid=0 running=1", instr_valid, running);
    end
    for (int i = 0; i < 4; i++) begin
      ra_seen[i] = read_address;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL seq[%0d]: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (fetch_pc !== AW'(i) || instr_valid !== 1'b1 || ra_seen[i] !== AW'(i)) begin
        errors++;
        $display("FAIL seq_lag[%0d]: fetch_pc=%0d ra=%0d valid=%b expected %0d/%0d/1",
                 i, fetch_pc, ra_seen[i], instr_valid, i, i);
      end
      if (instr_valid) begin
        checks++;
        if (rom_q !== rom_word(fetch_pc)) begin
          errors++;
          $display("FAIL seq_rom[%0d]: word=%h expected=%h", i, rom_q, rom_word(fetch_pc));
        end
      end
    end
  endtask

  task automatic test_jump_branch();
    do_reset();
    start_run();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (fetch_pc !== 8'd9) begin
      errors++;
      $display("FAIL jump_setup: fetch_pc=%0d expected 9", fetch_pc);
    end
    // jump to 4
    jump = 1; jump_target = 26'd4;
    tick();
    jump = 0;
    checks++;
    if (read_address !== 8'd4 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_bubble: ra=%0d valid=%b expected 4/0", read_address, instr_valid);
    end
    tick();
    checks++;
    if (fetch_pc !== 8'd4 || instr_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL jump_target: dut=%h model=%h expected fetch_pc 4 valid", obs_vec(), exp_vec());
    end
    tick(); tick();
    // branch +3 at fetch_pc 6 -> 10
    branch_taken = 1; branch_offset = 16'd3;
    tick();
    branch_taken = 0;
    checks++;
    if (read_address !== 8'd10 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_fwd_bubble: ra=%0d valid=%b expected 10/0", read_address, instr_valid);
    end
    tick();
    checks++;
    if (fetch_pc !== 8'd10 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL branch_fwd_target: fetch_pc=%0d valid=%b expected 10/1", fetch_pc, instr_valid);
    end
    // back to 6, then branch -2 -> 5; stall asserted too (redirect wins), jump beats branch
    jump = 1; jump_target = 26'd6; branch_taken = 1; branch_offset = 16'd100; stall = 1;
    tick();
    jump = 0; branch_taken = 0; stall = 0;
    tick();
    checks++;
    if (fetch_pc !== 8'd6 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL jump_over_branch: dut=%h model=%h expected fetch_pc 6", obs_vec(), exp_vec());
    end
    branch_taken = 1; branch_offset = 16'hFFFE;
    tick();
    branch_taken = 0;
    checks++;
    if (read_address !== 8'd5 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL branch_back_bubble: ra=%0d valid=%b expected 5/0", read_address, instr_valid);
    end
    tick();
    checks++;
    if (fetch_pc !== 8'd5 || instr_valid !== 1'b1 || rom_q !== rom_word(8'd5)) begin
      errors++;
      $display("FAIL branch_back_target: fetch_pc=%0d valid=%b word=%h expected 5/1/%h",
               fetch_pc, instr_valid, rom_q, rom_word(8'd5));
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) tick();
    held = rom_q;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (read_address !== 8'd2 || fetch_pc !== 8'd2 || instr_valid !== 1'b1 || rom_q !== held) begin
        errors++;
        $display("FAIL stall[%0d]: ra=%0d pc=%0d valid=%b word=%h expected 2/2/1/%h",
                 i, read_address, fetch_pc, instr_valid, rom_q, held);
      end
    end
    stall = 0;
    tick();
    checks++;
    if (fetch_pc !== 8'd3 || instr_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stall_release: dut=%h model=%h expected fetch_pc 3", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    start_run();
    tick();
    jump = 1; jump_target = 26'd250;
    tick();
    jump = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap[%0d]: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
`ifdef PC_BOUNDS_CHECK_EN
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || instr_valid !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL wrap_fault: fault=%b halted=%b valid=%b running=%b expected 1/1/0/0",
               fault, halted, instr_valid, running);
    end
`else
    checks++;
    if (fetch_pc !== 8'd1 || instr_valid !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero: fetch_pc=%0d valid=%b fault=%b expected 1/1/0",
               fetch_pc, instr_valid, fault);
    end
`endif
  endtask

  task automatic test_halt_and_async_reset();
    do_reset();
    start_run();
    for (int i = 0; i < 4; i++) tick();
    halt = 1;
    tick();
    halt = 0;
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: halted=%b running=%b valid=%b expected 1/0/0", halted, running, instr_valid);
    end
    start = 1; jump = 1; jump_target = 26'd7; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL halt_absorb[%0d]: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
    end
    clear_inputs();
    // async reset in the middle of a stall, checked before any clock edge
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) tick();
    stall = 1;
    tick(); tick();
    #2;
    reset = 1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== {AW'(RPC), AW'(RPC), 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: dut=%h expected=%h", obs_vec(), {AW'(RPC), AW'(RPC), 4'b0000});
    end
    @(negedge clk);
    reset = 0;
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (m_mode >= 2 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end
      start         = ($urandom_range(0, 5) == 0);
      halt          = ($urandom_range(0, 59) == 0);
      jump          = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      jump_target   = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'($urandom_range(0, N - 1));
      branch_offset = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 40)) - 16'd20;
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: dut=%h model=%h", i, obs_vec(), exp_vec());
      end
      if (instr_valid) begin
        checks++;
        if (rom_q !== rom_word(fetch_pc)) begin
          errors++;
          $display("FAIL random_rom[%0d]: word=%h expected=%h", i, rom_q, rom_word(fetch_pc));
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_jump_branch();
    test_stall();
    test_wrap();
    test_halt_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
